// File: rtl/dot_prod_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dot_prod_pkg : shared types and constants for the dot-product      |
// |                sequencer                                           |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
package dot_prod_pkg;

  localparam int DP_ADDR_W = 4;
  localparam int DP_CYC_W  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/dot_prod_addr_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dot_prod_addr_cnt : vector read-address counter with a last-address|
// |                     flag derived from the terminal count           |
// | Revision          : 1.0                                            |
// +--------------------------------------------------------------------+
module dot_prod_addr_cnt
  import dot_prod_pkg::*;
#(
  parameter int ADDR_W = DP_ADDR_W,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [LEN_W-1:0]  tc,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  w_tc_m1;

  // tc of zero wraps to all ones and never matches, so last stays low.
  assign w_tc_m1 = tc - LEN_W'(1);
  assign last    = (LEN_W'(r_addr) == w_tc_m1);
  assign addr    = r_addr;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_addr <= '0;
    end else if (en) begin
      r_addr <= r_addr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dot_prod_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dot_prod_ctrl : sequencer walking both vector BRAMs and gating the |
// |                 accumulator. Option: DOT_PROD_CTRL_CYCLE_CNT_EN    |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module dot_prod_ctrl
  import dot_prod_pkg::*;
#(
  parameter int ADDR_W = DP_ADDR_W,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              acc_clr,
  output logic              mac_en,
  output logic              busy,
  output logic              done
`ifdef DOT_PROD_CTRL_CYCLE_CNT_EN
  ,
  output logic [DP_CYC_W-1:0] cycle_cnt
`endif
);

  localparam logic [LEN_W-1:0] c_max_len = LEN_W'(2 ** ADDR_W);

  ctrl_state_e       r_state;
  ctrl_state_e       w_state_nxt;
  logic [LEN_W-1:0]  r_len_q;
  logic              r_mac_en;
  logic              w_accept;
  logic              w_last;
  logic              w_cnt_en;

  assign w_accept = ((r_state == IDLE) || (r_state == DONE)) && start && !abort;
  assign w_cnt_en = (r_state == RUN) && !w_last;

  dot_prod_addr_cnt #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_accept),
    .en   (w_cnt_en),
    .tc   (r_len_q),
    .addr (rd_addr),
    .last (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, DONE: if (start) w_state_nxt = CLEAR;
      CLEAR:      w_state_nxt = (r_len_q == '0) ? DONE : RUN;
      RUN:        if (w_last) w_state_nxt = DRAIN;
      DRAIN:      w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
    // Abort overrides everything, including a simultaneous start.
    if (abort) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len_q <= '0;
    end else if (w_accept) begin
      r_len_q <= (len > c_max_len) ? c_max_len : len;
    end
  end

  // Tracks the one-cycle BRAM latency; abort squashes the pending enable.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      r_mac_en <= 1'b0;
    end else begin
      r_mac_en <= rd_en;
    end
  end

  assign rd_en   = (r_state == RUN);
  assign acc_clr = (r_state == CLEAR);
  assign busy    = (r_state == CLEAR) || (r_state == RUN) || (r_state == DRAIN);
  assign done    = (r_state == DONE);
  assign mac_en  = r_mac_en;

`ifdef DOT_PROD_CTRL_CYCLE_CNT_EN
  logic [DP_CYC_W-1:0] r_cycle_cnt;

  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_cycle_cnt <= '0;
    end else if (busy && (r_cycle_cnt != '1)) begin
      r_cycle_cnt <= r_cycle_cnt + 1'b1;
    end
  end

  assign cycle_cnt = r_cycle_cnt;
`else
  // Cycle counter not built.
`endif

endmodule
`default_nettype wire

// File: tb/tb_dot_prod_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dot_prod_ctrl : directed self-checking bench for dot_prod_ctrl  |
// | Revision         : 1.0                                             |
// +--------------------------------------------------------------------+
module tb_dot_prod_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] len;
  logic       abort;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic       acc_clr;
  logic       mac_en;
  logic       busy;
  logic       done;
`ifdef DOT_PROD_CTRL_CYCLE_CNT_EN
  logic [15:0] cycle_cnt;
`endif

  int checks = 0;
  int errors = 0;

  dot_prod_ctrl #(
    .ADDR_W (4),
    .LEN_W  (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .acc_clr   (acc_clr),
    .mac_en    (mac_en),
    .busy      (busy),
    .done      (done)
`ifdef DOT_PROD_CTRL_CYCLE_CNT_EN
    ,
    .cycle_cnt (cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({acc_clr, rd_en, mac_en, busy, done, rd_addr} !== 9'b0) begin
      errors++;
      $display("FAIL reset outs=%b addr=%0d required all zero",
               {acc_clr, rd_en, mac_en, busy, done}, rd_addr);
    end
`ifdef DOT_PROD_CTRL_CYCLE_CNT_EN
    checks++;
    if (cycle_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cycle_cnt got=%0d required=0", cycle_cnt);
    end
`endif
    rst = 1'b0;
    tick();
  endtask

  // Cycle k=1 is the first cycle after the accepting edge T.
  task automatic test_op(input logic [4:0] l, input int n, input string name);
    logic [4:0] exp_o;
    int         exp_a;
    start = 1'b1; len = l;
    tick();
    start = 1'b0; len = '0;
    for (int k = 1; k <= n + 4; k++) begin
      exp_o[4] = (k == 1);                                 // acc_clr
      exp_o[3] = (k >= 2) && (k <= n + 1);                 // rd_en
      exp_o[2] = (k >= 3) && (k <= n + 2);                 // mac_en
      exp_o[1] = (n == 0) ? (k == 1) : (k <= n + 2);       // busy
      exp_o[0] = (n == 0) ? (k >= 2) : (k >= n + 3);       // done
      exp_a    = (n == 0 || k < 2) ? 0 : ((k <= n + 1) ? k - 2 : n - 1);
      checks++;
      if ({acc_clr, rd_en, mac_en, busy, done} !== exp_o) begin
        errors++;
        $display("FAIL %s k=%0d clr/rd/mac/busy/done got=%b required=%b",
                 name, k, {acc_clr, rd_en, mac_en, busy, done}, exp_o);
      end
      checks++;
      if (rd_addr !== 4'(exp_a)) begin
        errors++;
        $display("FAIL %s_addr k=%0d got=%0d required=%0d", name, k, rd_addr, exp_a);
      end
`ifdef DOT_PROD_CTRL_CYCLE_CNT_EN
      if (k == 1 || k == n + 4) begin
        checks++;
        if (cycle_cnt !== ((k == 1) ? 16'd0 : ((n == 0) ? 16'd1 : 16'(n + 2)))) begin
          errors++;
          $display("FAIL %s_cycle_cnt k=%0d got=%0d", name, k, cycle_cnt);
        end
      end
`endif
      tick();
    end
  endtask

  task automatic test_lengths();
    test_op(5'd5, 5, "len5");
    test_op(5'd0, 0, "len0");
    test_op(5'd16, 16, "len16");
    test_op(5'd31, 16, "len31");
    test_op(5'd1, 1, "len1");
  endtask

  task automatic test_abort();
    start = 1'b1; len = 5'd8;
    tick();
    start = 1'b0;
    tick(); tick();              // CLEAR, RUN #1 now; k=3 is RUN #2
    tick();                      // k=4: third RUN cycle
    checks++;
    if (rd_en !== 1'b1 || rd_addr !== 4'd2) begin
      errors++;
      $display("FAIL abort_pre rd_en=%b addr=%0d required rd_en=1 addr=2", rd_en, rd_addr);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({acc_clr, rd_en, mac_en, busy, done} !== 5'b0) begin
        errors++;
        $display("FAIL abort_post c=%0d outs=%b required=00000", k,
                 {acc_clr, rd_en, mac_en, busy, done});
      end
      tick();
    end
    test_op(5'd2, 2, "after_abort");
  endtask

  task automatic test_start_ignored();
    int rd_cnt = 0;
    int done_k = 0;
    start = 1'b1; len = 5'd4;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      start = (k == 3);
      len   = (k == 3) ? 5'd9 : 5'd0;
      if (rd_en === 1'b1) rd_cnt++;
      if (done === 1'b1 && done_k == 0) done_k = k;
      tick();
    end
    start = 1'b0;
    checks++;
    if (rd_cnt != 4) begin
      errors++;
      $display("FAIL busy_start rd_cycles got=%0d required=4", rd_cnt);
    end
    checks++;
    if (done_k != 7) begin
      errors++;
      $display("FAIL busy_start done_cycle got=%0d required=7", done_k);
    end
    // In DONE: a restart with len=3 drops done on the next cycle.
    test_op(5'd3, 3, "restart");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b1; abort = 1'b1; len = 5'd5;
    tick();
    start = 1'b0; abort = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({acc_clr, busy, done, rd_en} !== 4'b0) begin
        errors++;
        $display("FAIL start_abort c=%0d clr/busy/done/rd got=%b required=0000", k,
                 {acc_clr, busy, done, rd_en});
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; len = 5'd8;
    tick();
    start = 1'b0;
    tick(); tick(); tick();      // RUN, rd_en and mac_en both active
    checks++;
    if (rd_en !== 1'b1 || mac_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre rd_en=%b mac_en=%b required 1 1", rd_en, mac_en);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({acc_clr, rd_en, mac_en, busy, done, rd_addr} !== 9'b0) begin
      errors++;
      $display("FAIL rst_mid outs=%b addr=%0d required all zero",
               {acc_clr, rd_en, mac_en, busy, done}, rd_addr);
    end
    rst = 1'b0;
    tick(); tick();
    checks++;
    if ({rd_en, mac_en, busy, done} !== 4'b0) begin
      errors++;
      $display("FAIL rst_after rd/mac/busy/done got=%b required=0000",
               {rd_en, mac_en, busy, done});
    end
  endtask

  initial begin
    test_reset();
    test_lengths();
    test_abort();
    test_start_ignored();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dot_prod_ctrl.md
Name: dot_prod_ctrl

Overview:
Sequencer for the dot-product datapath. On a start pulse it clears the accumulator register and walks both vector memories from address 0 to len-1. It enables the multiply-accumulate one cycle after each read to match the 1-cycle memory latency, then raises done. It sits between the AXI-Lite register slave (start/len/abort/done/busy) and the vector BRAMs plus accumulator (rd_en/rd_addr/acc_clr/mac_en).

Parameters:
ADDR_W, 4, vector memory address width; maximum vector length is 2**ADDR_W
LEN_W, ADDR_W+1, width of the len input; must represent 0..2**ADDR_W

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  operation request; accepted only in IDLE or DONE
len  in  LEN_W  element count; sampled on the accepted start
abort  in  1  cancel any operation; return to IDLE
rd_en  out  1  read enable to both vector memories
rd_addr  out  ADDR_W  read address to both vector memories
acc_clr  out  1  one-cycle clear to the accumulator register
mac_en  out  1  accumulate enable; the registered copy of rd_en
busy  out  1  high in CLEAR, RUN and DRAIN
done  out  1  level; high in DONE until the next accepted start, abort or rst

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst.
- Reset: state=IDLE; all outputs are 0; len_q=0; rd_addr=0; mac_en pipeline flop=0. Reset mid-operation behaves identically, and no further rd_en/mac_en is issued.
- States: IDLE, CLEAR, RUN, DRAIN, DONE (Moore outputs).
- IDLE/DONE, start=1 and abort=0 -> CLEAR:
  - len_q <= min(len, 2**ADDR_W).
  - rd_addr <= 0.
  - done drops on the same edge.
- CLEAR: acc_clr=1 for exactly one cycle.
  - If len_q=0, go to DONE; no rd_en or mac_en is issued and the result is 0.
  - Otherwise go to RUN.
- RUN: rd_en=1 and rd_addr increments by 1 each cycle.
  - After len_q cycles (last address len_q-1), go to DRAIN.
  - rd_addr holds its last value in DRAIN; it is not wrapped.
- DRAIN: one cycle; mac_en is high for the last element; then go to DONE.
- mac_en <= rd_en registered. It is high exactly len_q cycles, offset +1 from rd_en.
- Latency for len=N>0, with start accepted at edge T:
  - acc_clr in cycle T+1.
  - rd_en in T+2..T+N+1.
  - mac_en in T+3..T+N+2.
  - done=1 from T+N+3.
- Latency for len=0: done=1 from T+2.
- start while busy=1 is ignored; there is no queuing.
- start in DONE restarts a new operation.
- abort=1 in any state: next state is IDLE, and rd_en, mac_en, acc_clr and done all go 0 on the next edge. The pending mac_en flop is squashed on that same edge, so the partial accumulator value stays as-is.
- abort and start in the same cycle: abort wins.
- len > 2**ADDR_W: clamped to 2**ADDR_W. Example: ADDR_W=4, len=31 -> 16 elements.
- busy and done are never high simultaneously.

Optional Feature:
DOT_PROD_CTRL_CYCLE_CNT_EN:
- Defined: adds output cycle_cnt (16 bits). It resets to 0 on an accepted start and increments in every busy cycle, saturating at 16'hFFFF. It holds in DONE and IDLE and is readable by the register slave. Expected value is len+2, or 1 for len=0. It resets to 0 on rst.
- Undefined: the port and the counter are absent; all other behaviour is unchanged.

Decomposition:
- Package dot_prod_pkg:
  - ctrl_state_e enum (IDLE, CLEAR, RUN, DRAIN, DONE).
  - DP_ADDR_W default constant.
  - DP_CYC_W=16.
- Sub-module dot_prod_addr_cnt: ADDR_W counter with rst, clr, en, a terminal-count input (len_q) and a last-address flag. It is used for rd_addr and RUN termination.
- The FSM, len clamp and mac_en flop stay in dot_prod_ctrl.

Test Plan:
- ADDR_W=4, start at T with len=5 -> acc_clr @T+1; rd_en @T+2..T+6 with rd_addr 0,1,2,3,4; mac_en @T+3..T+7; done=1 @T+8 and busy=0.
- len=0 -> acc_clr @T+1, no rd_en/mac_en, done @T+2.
- len=16 and len=31 -> both give exactly 16 rd_en cycles with addresses 0..15, no wrap to 0, and done @T+19.
- len=8, abort asserted in the third RUN cycle -> IDLE next cycle; rd_en and mac_en both 0 from that cycle; done stays 0. A following start with len=2 completes normally.
- Start pulse during RUN (len=4) is ignored; start and abort together in IDLE -> stays IDLE. Start in DONE with len=3 -> done drops the next cycle and the new operation runs.
- rst asserted mid-RUN -> all outputs 0 on the next edge. With DOT_PROD_CTRL_CYCLE_CNT_EN and len=5, cycle_cnt=7 at done.
